alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_if.sv | 39 +++
 rtl/alu_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Command handshake and downstream-ALU bus for alu_seq_ctrl.
// The master side issues commands and plays the ALU; the slave side is the controller.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_op;
  logic [3:0]       cmd_rdest;
  logic [3:0]       cmd_rsrc;
  logic [WIDTH-1:0] cmd_imm;
  logic             cmd_use_imm;
  logic [4:0]       cmd_shamt;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_op;
  logic [4:0]       alu_shamt;
  logic             alu_psr_c;
  logic             alu_flags_en;
  logic [4:0]       alu_flags_sel;
  logic [WIDTH-1:0] alu_y;
  logic             alu_y_valid;
  logic [4:0]       alu_flags_out;

  modport master (
    output cmd_valid, cmd_op, cmd_rdest, cmd_rsrc, cmd_imm, cmd_use_imm, cmd_shamt,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op, alu_shamt, alu_psr_c, alu_flags_en, alu_flags_sel,
    output alu_y, alu_y_valid, alu_flags_out
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rdest, cmd_rsrc, cmd_imm, cmd_use_imm, cmd_shamt,
    output cmd_ready,
    output alu_a, alu_b, alu_op, alu_shamt, alu_psr_c, alu_flags_en, alu_flags_sel,
    input  alu_y, alu_y_valid, alu_flags_out
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for an external ALU: register file, PSR and an IDLE->EXEC->WB command FSM.
// Optional macro ALU_SEQ_R0_ZERO_EN makes r0 a hard-wired zero register.
module alu_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_seq_ctrl_if.slave    bus,
  output logic             done,
  output logic [4:0]       psr,
  output logic             busy,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [4:0] OP_NOP = 5'd29;

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] rf      [NREG];
  logic [WIDTH-1:0] rf_view [NREG];

  logic [4:0]       op_q;
  logic [3:0]       rdest_q;
  logic [3:0]       rsrc_q;
  logic [WIDTH-1:0] imm_q;
  logic             use_imm_q;
  logic [4:0]       shamt_q;

  logic [4:0]       sel_q;
  logic             wr_en;

  // Read view of the register file; r0 reads as zero when the macro is set.
  always_comb begin
    rf_view = rf;
`ifdef ALU_SEQ_R0_ZERO_EN
    rf_view[0] = '0;
`endif
  end

  assign dbg_data = rf_view[dbg_addr];

  always_comb begin
    sel_q = 5'b00000;
    case (op_q)
      5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9: sel_q = 5'b11101;
      5'd10, 5'd11, 5'd12, 5'd13:         sel_q = 5'b00111;
      default:                            sel_q = 5'b00000;
    endcase
  end

  always_comb begin
`ifdef ALU_SEQ_R0_ZERO_EN
    wr_en = (state == WB) && bus.alu_y_valid && (rdest_q != 4'd0);
`else
    wr_en = (state == WB) && bus.alu_y_valid;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.cmd_valid) next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands are driven from latched fields for the whole of EXEC and WB so the
  // ALU sees a stable request; the register write only lands at the end of WB.
  always_comb begin
    bus.cmd_ready     = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    bus.alu_a         = '0;
    bus.alu_b         = '0;
    bus.alu_op        = OP_NOP;
    bus.alu_shamt     = 5'd0;
    bus.alu_psr_c     = 1'b0;
    bus.alu_flags_en  = 1'b0;
    bus.alu_flags_sel = 5'b00000;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      EXEC, WB: begin
        bus.alu_a         = rf_view[rdest_q];
        bus.alu_b         = use_imm_q ? imm_q : rf_view[rsrc_q];
        bus.alu_op        = op_q;
        bus.alu_shamt     = shamt_q;
        bus.alu_psr_c     = psr[4];
        bus.alu_flags_sel = sel_q;
        if (state == WB) begin
          bus.alu_flags_en = 1'b1;
          done             = 1'b1;
        end
      end
      default: begin
        bus.cmd_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 5'd0;
      rdest_q   <= 4'd0;
      rsrc_q    <= 4'd0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      shamt_q   <= 5'd0;
      psr       <= 5'b00000;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        op_q      <= bus.cmd_op;
        rdest_q   <= bus.cmd_rdest;
        rsrc_q    <= bus.cmd_rsrc;
        imm_q     <= bus.cmd_imm;
        use_imm_q <= bus.cmd_use_imm;
        shamt_q   <= bus.cmd_shamt;
      end
      if (state == WB) begin
        if (wr_en) rf[rdest_q] <= bus.alu_y;
        psr <= (psr & ~sel_q) | bus.alu_flags_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: the bench plays the downstream ALU and
// keeps its own register-file/PSR model. Honours ALU_SEQ_R0_ZERO_EN if defined.
module tb_alu_seq_ctrl;

  typedef struct packed {
    logic [15:0] y;
    logic        v;
    logic [4:0]  f;
  } alu_res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_data;
  logic        done;
  logic        busy;
  logic [4:0]  psr;
  logic        force_invalid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_count = 0;
  int hs_cycles[$];

  logic [15:0] ref_rf [16];
  logic [4:0]  ref_psr;

  alu_seq_ctrl_if #(.WIDTH(16)) bus ();

  alu_seq_ctrl #(.WIDTH(16), .NREG(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .done     (done),
    .psr      (psr),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) hs_cycles.push_back(cycle);
    if (done === 1'b1) done_count++;
  end

  // Behavioural ALU: flags {C,F,Z,L,N}; compares produce no result.
  function automatic alu_res_t alu_model(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    alu_res_t r;
    logic [16:0] s;
    r = '0;
    s = '0;
    case (op)
      5'd0, 5'd1, 5'd4, 5'd5: begin
        s = {1'b0, a} + {1'b0, b} + ((op == 5'd4 || op == 5'd5) ? {16'd0, cin} : 17'd0);
        r.y = s[15:0];
        r.v = 1'b1;
        r.f = {s[16], (a[15] == b[15]) && (s[15] != a[15]), s[15:0] == 16'd0, 1'b0, s[15]};
      end
      5'd8, 5'd9: begin
        s = {1'b0, a} - {1'b0, b};
        r.y = s[15:0];
        r.v = 1'b1;
        r.f = {s[16], (a[15] != b[15]) && (s[15] != a[15]), s[15:0] == 16'd0, 1'b0, s[15]};
      end
      5'd10, 5'd11, 5'd12, 5'd13: begin
        r.v = 1'b0;
        r.f = {2'b00, a == b, a < b, $signed(a) < $signed(b)};
      end
      5'd31: begin
        r.y = b;
        r.v = 1'b1;
      end
      default: begin
        r.y = a ^ b;
        r.v = 1'b1;
      end
    endcase
    return r;
  endfunction

  function automatic logic [4:0] sel_model(input logic [4:0] op);
    if (op inside {5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9}) return 5'b11101;
    if (op inside {[5'd10:5'd13]}) return 5'b00111;
    return 5'b00000;
  endfunction

  function automatic logic [15:0] ref_read(input logic [3:0] idx);
`ifdef ALU_SEQ_R0_ZERO_EN
    if (idx == 4'd0) return 16'h0000;
`endif
    return ref_rf[idx];
  endfunction

  always_comb begin
    alu_res_t e;
    e = alu_model(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_psr_c);
    bus.alu_y         = e.y;
    bus.alu_y_valid   = e.v & ~force_invalid;
    bus.alu_flags_out = e.f;
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0000;
    ref_psr = 5'b00000;
  endtask

  task automatic model_apply(input logic [4:0] op, input logic [3:0] rdest, input logic [3:0] rsrc,
                             input logic [15:0] imm, input logic use_imm, input logic inval);
    alu_res_t r;
    logic [4:0] sel;
    r   = alu_model(op, ref_read(rdest), use_imm ? imm : ref_read(rsrc), ref_psr[4]);
    sel = sel_model(op);
    if (r.v && !inval) ref_rf[rdest] = r.y;
    ref_psr = (ref_psr & ~sel) | r.f;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  // One full command with protocol checks in EXEC, WB and the following IDLE.
  task automatic run_cmd(input logic [4:0] op, input logic [3:0] rdest, input logic [3:0] rsrc,
                         input logic [15:0] imm, input logic use_imm, input logic [4:0] shamt,
                         input logic inval);
    logic [15:0] ea, eb;
    logic [4:0]  esel;
    logic        ec;
    int          d0;
    ea   = ref_read(rdest);
    eb   = use_imm ? imm : ref_read(rsrc);
    esel = sel_model(op);
    ec   = ref_psr[4];
    wait_ready();
    d0 = done_count;
    bus.cmd_op = op; bus.cmd_rdest = rdest; bus.cmd_rsrc = rsrc;
    bus.cmd_imm = imm; bus.cmd_use_imm = use_imm; bus.cmd_shamt = shamt;
    bus.cmd_valid = 1'b1;
    force_invalid = inval;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || bus.cmd_ready !== 1'b0) begin errors++;
      $display("[TB] FAIL exec_status: busy=%b done=%b ready=%b required 1 0 0", busy, done, bus.cmd_ready); end
    checks++; if (bus.alu_a !== ea || bus.alu_b !== eb) begin errors++;
      $display("[TB] FAIL exec_operands: a=%h b=%h required a=%h b=%h", bus.alu_a, bus.alu_b, ea, eb); end
    checks++; if (bus.alu_op !== op || bus.alu_shamt !== shamt || bus.alu_psr_c !== ec) begin errors++;
      $display("[TB] FAIL exec_ctrl: op=%0d shamt=%0d c=%b required op=%0d shamt=%0d c=%b",
               bus.alu_op, bus.alu_shamt, bus.alu_psr_c, op, shamt, ec); end
    checks++; if (bus.alu_flags_sel !== esel || bus.alu_flags_en !== 1'b0) begin errors++;
      $display("[TB] FAIL exec_flags: sel=%b en=%b required sel=%b en=0", bus.alu_flags_sel, bus.alu_flags_en, esel); end
    bus.cmd_op = 5'($urandom); bus.cmd_rdest = 4'($urandom); bus.cmd_rsrc = 4'($urandom);
    bus.cmd_imm = 16'($urandom); bus.cmd_use_imm = ~use_imm;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || bus.alu_flags_en !== 1'b1) begin errors++;
      $display("[TB] FAIL wb_status: done=%b flags_en=%b required 1 1", done, bus.alu_flags_en); end
    checks++; if (bus.alu_a !== ea || bus.alu_b !== eb || bus.alu_op !== op) begin errors++;
      $display("[TB] FAIL wb_hold: a=%h b=%h op=%0d required a=%h b=%h op=%0d",
               bus.alu_a, bus.alu_b, bus.alu_op, ea, eb, op); end
    bus.cmd_valid = 1'b0;
    model_apply(op, rdest, rsrc, imm, use_imm, inval);
    @(posedge clk); #1;
    force_invalid = 1'b0;
    dbg_addr = rdest;
    #1;
    checks++; if (done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.alu_op !== 5'd29 || bus.alu_a !== 16'h0000) begin errors++;
      $display("[TB] FAIL idle_outputs: done=%b ready=%b op=%0d a=%h required 0 1 29 0000",
               done, bus.cmd_ready, bus.alu_op, bus.alu_a); end
    checks++; if (dbg_data !== ref_read(rdest) || psr !== ref_psr) begin errors++;
      $display("[TB] FAIL writeback: r%0d=%h psr=%b required %h %b", rdest, dbg_data, psr, ref_read(rdest), ref_psr); end
    checks++; if (done_count != d0 + 1) begin errors++;
      $display("[TB] FAIL done_pulses: got %0d required 1", done_count - d0); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || psr !== 5'b00000 || bus.alu_op !== 5'd29) begin
      errors++; $display("[TB] FAIL reset_state: ready=%b busy=%b done=%b psr=%b op=%0d required 1 0 0 00000 29",
                         bus.cmd_ready, busy, done, psr, bus.alu_op); end
    @(negedge clk) reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++;
        $display("[TB] FAIL reset_rf: r%0d=%h required 0000", i, dbg_data); end
    end
  endtask

  task automatic test_addi();
    run_cmd(5'd1, 4'd1, 4'd0, 16'h0005, 1'b1, 5'd0, 1'b0);
    dbg_addr = 4'd1; #1;
    checks++; if (dbg_data !== 16'h0005 || psr !== 5'b00000) begin errors++;
      $display("[TB] FAIL addi_result: r1=%h psr=%b required 0005 00000", dbg_data, psr); end
  endtask

  task automatic test_carry_chain();
    run_cmd(5'd1, 4'd1, 4'd0, 16'hFFFA, 1'b1, 5'd0, 1'b0);
    run_cmd(5'd1, 4'd1, 4'd0, 16'h0001, 1'b1, 5'd0, 1'b0);
    dbg_addr = 4'd1; #1;
    checks++; if (dbg_data !== 16'h0000 || psr[4] !== 1'b1 || psr[2] !== 1'b1) begin errors++;
      $display("[TB] FAIL carry_wrap: r1=%h psr=%b required 0000 C=1 Z=1", dbg_data, psr); end
    run_cmd(5'd5, 4'd2, 4'd2, 16'h0000, 1'b1, 5'd0, 1'b0);
    dbg_addr = 4'd2; #1;
    checks++; if (dbg_data !== 16'h0001) begin errors++;
      $display("[TB] FAIL addc_carry_in: r2=%h required 0001", dbg_data); end
  endtask

  task automatic test_cmp();
    run_cmd(5'd1, 4'd3, 4'd0, 16'h0003, 1'b1, 5'd0, 1'b0);
    run_cmd(5'd1, 4'd4, 4'd0, 16'h0007, 1'b1, 5'd0, 1'b0);
    run_cmd(5'd1, 4'd8, 4'd0, 16'hFFFF, 1'b1, 5'd0, 1'b0);
    run_cmd(5'd1, 4'd8, 4'd0, 16'h0001, 1'b1, 5'd0, 1'b0);
    run_cmd(5'd10, 4'd3, 4'd4, 16'h0000, 1'b0, 5'd0, 1'b0);
    dbg_addr = 4'd3; #1;
    checks++; if (dbg_data !== 16'h0003 || psr !== 5'b10011) begin errors++;
      $display("[TB] FAIL cmp_flags: r3=%h psr=%b required 0003 10011", dbg_data, psr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  rd [3];
    logic [15:0] im [3];
    int base, k, since;
    rd[0] = 4'd6; rd[1] = 4'd7; rd[2] = 4'd6;
    im[0] = 16'h0011; im[1] = 16'h0022; im[2] = 16'h0033;
    wait_ready();
    base = hs_cycles.size();
    k = 0;
    since = 99;
    bus.cmd_op = 5'd1; bus.cmd_rdest = rd[0]; bus.cmd_rsrc = 4'd0;
    bus.cmd_imm = im[0]; bus.cmd_use_imm = 1'b1; bus.cmd_shamt = 5'd0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(posedge clk); #1;
      since++;
      if (hs_cycles.size() > base + k) begin
        model_apply(5'd1, rd[k], 4'd0, im[k], 1'b1, 1'b0);
        k++;
        since = 0;
        if (k < 3) begin bus.cmd_rdest = rd[k]; bus.cmd_imm = im[k]; end
      end
      if (since < 2) begin
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
          $display("[TB] FAIL b2b_ready_low: ready=%b required 0 (%0d cycles after handshake)", bus.cmd_ready, since); end
      end
    end
    bus.cmd_valid = 1'b0;
    checks++; if (k != 3) begin errors++;
      $display("[TB] FAIL b2b_timeout: handshakes=%0d required 3", k); end
    if (k == 3) begin
      checks++; if (hs_cycles[base+1] - hs_cycles[base] != 3 || hs_cycles[base+2] - hs_cycles[base+1] != 3) begin errors++;
        $display("[TB] FAIL b2b_spacing: gaps=%0d,%0d required 3,3",
                 hs_cycles[base+1] - hs_cycles[base], hs_cycles[base+2] - hs_cycles[base+1]); end
    end
    repeat (3) @(posedge clk);
    #1;
    dbg_addr = 4'd6; #1;
    checks++; if (dbg_data !== ref_read(4'd6)) begin errors++;
      $display("[TB] FAIL b2b_r6: got %h required %h", dbg_data, ref_read(4'd6)); end
    dbg_addr = 4'd7; #1;
    checks++; if (dbg_data !== ref_read(4'd7) || psr !== ref_psr) begin errors++;
      $display("[TB] FAIL b2b_r7: r7=%h psr=%b required %h %b", dbg_data, psr, ref_read(4'd7), ref_psr); end
  endtask

  task automatic test_random();
    logic [4:0] pool [15];
    pool = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd2, 5'd3, 5'd29, 5'd31, 5'd20};
    for (int i = 0; i < 40; i++) begin
      run_cmd(pool[$urandom_range(0, 14)], 4'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom), 5'($urandom), ($urandom_range(0, 4) == 0));
    end
  endtask

  task automatic test_reset_abort();
    run_cmd(5'd1, 4'd5, 4'd0, 16'h1234, 1'b1, 5'd0, 1'b0);
    wait_ready();
    bus.cmd_op = 5'd1; bus.cmd_rdest = 4'd5; bus.cmd_rsrc = 4'd0;
    bus.cmd_imm = 16'h0009; bus.cmd_use_imm = 1'b1; bus.cmd_shamt = 5'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++;
      $display("[TB] FAIL abort_in_wb: done=%b required 1", done); end
    reset = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1 || done !== 1'b0 || psr !== 5'b00000) begin errors++;
      $display("[TB] FAIL abort_async: ready=%b done=%b psr=%b required 1 0 00000", bus.cmd_ready, done, psr); end
    @(negedge clk) reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    dbg_addr = 4'd5; #1;
    checks++; if (bus.cmd_ready !== 1'b1 || dbg_data !== 16'h0000 || psr !== 5'b00000) begin errors++;
      $display("[TB] FAIL abort_result: ready=%b r5=%h psr=%b required 1 0000 00000", bus.cmd_ready, dbg_data, psr); end
  endtask

  task automatic test_r0();
    run_cmd(5'd1, 4'd0, 4'd0, 16'h0007, 1'b1, 5'd0, 1'b0);
    dbg_addr = 4'd0; #1;
`ifdef ALU_SEQ_R0_ZERO_EN
    checks++; if (dbg_data !== 16'h0000) begin errors++;
      $display("[TB] FAIL r0_zero: r0=%h required 0000", dbg_data); end
`else
    checks++; if (dbg_data !== 16'h0007) begin errors++;
      $display("[TB] FAIL r0_normal: r0=%h required 0007", dbg_data); end
`endif
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 5'd0; bus.cmd_rdest = 4'd0; bus.cmd_rsrc = 4'd0;
    bus.cmd_imm = 16'h0000; bus.cmd_use_imm = 1'b0; bus.cmd_shamt = 5'd0;
    model_reset();
    test_reset();
    test_addi();
    test_carry_chain();
    test_cmp();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_r0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
